// File: rtl/axil_mem_pkg.sv
// axil_mem_pkg: response codes, FSM state encodings and LFSR constants for the AXI4-Lite memory slave
package axil_mem_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 mapped onto bit indices 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_e;
endpackage

// File: rtl/axil_mem_if.sv
// axil_mem_if: AXI4-Lite bus bundle between the core-side master and the memory slave
interface axil_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_mem_lfsr.sv
// axil_mem_lfsr: 16-bit Fibonacci LFSR whose low bit requests a ready stall
module axil_mem_lfsr
  import axil_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic en_o
);
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign en_o = lfsr_q[0];
endmodule

// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite word memory with configurable read/write latency and address error responses.
// Define AXIL_MEM_STALL_EN to add pseudo-random stalls on arready/awready/wready.
module axil_mem_slave
  import axil_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input logic clk,
  input logic rst,
  axil_mem_if.slave bus
);
  localparam int B = DATA_W / 8;
  localparam int OB = $clog2(B);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH_WORDS * B);
  function automatic logic [1:0] decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off >= MEM_BYTES ? RESP_DECERR : off[OB-1:0] != '0 ? RESP_SLVERR : RESP_OKAY;
  endfunction
  function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IW'(off >> OB);
  endfunction
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic stall;
`ifdef AXIL_MEM_STALL_EN
  axil_mem_lfsr u_lfsr (.clk(clk), .rst(rst), .en_o(stall));
`else
  assign stall = 1'b0;
`endif
  r_state_e r_q, r_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] raddr_q, r_addr;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] rresp_q;
  logic ar_hs, r_load;
  always_comb begin
    r_d = r_q;
    rcnt_d = rcnt_q;
    ar_hs = bus.arvalid && bus.arready;
    if (ar_hs) begin
      r_d = RD_LAT == 0 ? R_RESP : R_WAIT;
      rcnt_d = 4'(RD_LAT);
    end else if (r_q == R_WAIT) begin
      r_d = rcnt_q == 4'd1 ? R_RESP : R_WAIT;
      rcnt_d = rcnt_q - 4'd1;
    end else if (r_q == R_RESP && bus.rready) begin
      r_d = R_IDLE;
    end
    // zero-latency reads sample the address straight off the bus
    r_addr = r_q == R_IDLE ? bus.araddr : raddr_q;
    r_load = r_d == R_RESP && r_q != R_RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= R_IDLE;
      rcnt_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_q <= r_d;
      rcnt_q <= rcnt_d;
      if (ar_hs) raddr_q <= bus.araddr;
      if (r_load) begin
        rresp_q <= decode(r_addr);
        rdata_q <= decode(r_addr) == RESP_OKAY ? mem_q[widx(r_addr)] : '0;
      end
    end
  end
  w_state_e w_q, w_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic aw_held_q, w_held_q, aw_held_d, w_held_d;
  logic [ADDR_W-1:0] awaddr_q, w_addr;
  logic [DATA_W-1:0] wdata_q, w_data;
  logic [B-1:0] wstrb_q, w_strb;
  logic [1:0] bresp_q;
  logic aw_hs, w_hs, commit;
  always_comb begin
    w_d = w_q;
    wcnt_d = wcnt_q;
    aw_hs = bus.awvalid && bus.awready;
    w_hs = bus.wvalid && bus.wready;
    aw_held_d = aw_held_q || aw_hs;
    w_held_d = w_held_q || w_hs;
    if (w_q == W_COLLECT && aw_held_d && w_held_d) begin
      w_d = WR_LAT == 0 ? W_RESP : W_WAIT;
      wcnt_d = 4'(WR_LAT);
    end else if (w_q == W_WAIT) begin
      w_d = wcnt_q == 4'd1 ? W_RESP : W_WAIT;
      wcnt_d = wcnt_q - 4'd1;
    end else if (w_q == W_RESP && bus.bready) begin
      w_d = W_COLLECT;
      aw_held_d = 1'b0;
      w_held_d = 1'b0;
    end
    w_addr = aw_hs ? bus.awaddr : awaddr_q;
    w_data = w_hs ? bus.wdata : wdata_q;
    w_strb = w_hs ? bus.wstrb : wstrb_q;
    commit = w_d == W_RESP && w_q != W_RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= W_COLLECT;
      wcnt_q <= '0;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      w_q <= w_d;
      wcnt_q <= wcnt_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      if (aw_hs) awaddr_q <= bus.awaddr;
      if (w_hs) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      if (commit) bresp_q <= decode(w_addr);
    end
  end
  // memory has no reset; a read sampling the same edge sees the pre-write word
  always_ff @(posedge clk) begin
    if (!rst && commit && decode(w_addr) == RESP_OKAY)
      for (int i = 0; i < B; i++)
        if (w_strb[i]) mem_q[widx(w_addr)][i*8 +: 8] <= w_data[i*8 +: 8];
  end
  assign bus.arready = !rst && !stall && r_q == R_IDLE;
  assign bus.rvalid = !rst && r_q == R_RESP;
  assign bus.rdata = rst ? '0 : rdata_q;
  assign bus.rresp = rst ? RESP_OKAY : rresp_q;
  assign bus.awready = !rst && !stall && w_q == W_COLLECT && !aw_held_q;
  assign bus.wready = !rst && !stall && w_q == W_COLLECT && !w_held_q;
  assign bus.bvalid = !rst && w_q == W_RESP;
  assign bus.bresp = rst ? RESP_OKAY : bresp_q;
endmodule

// File: tb/tb_axil_mem_slave.sv
// tb_axil_mem_slave: scoreboard bench for axil_mem_slave covering latency, strobes, errors, backpressure, collision and reset abort
module tb_axil_mem_slave;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef AXIL_MEM_STALL_EN
  localparam int NRAND = 1000;
`else
  localparam int NRAND = 200;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axil_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axil_mem_slave #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(4096), .BASE_ADDR(BASE),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [1:0] resp;
    logic [31:0] data;
  } rexp_t;
  rexp_t rq[$];
  logic [1:0] bq[$];
  logic [31:0] mdl [int];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off >= 32'h4000) return 2'b11;
    if (off[1:0] != 2'b00) return 2'b10;
    return 2'b00;
  endfunction
  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[13:2]);
  endfunction
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly);
    bit ad = 0;
    bit wd = 0;
    bit seen = 0;
    int last = 0;
    logic [31:0] tmp;
    logic [1:0] e;
    bq.push_back(exp_resp(a));
    @(negedge clk);
    bus.wvalid = 1'b1;
    bus.wdata = d;
    bus.wstrb = s;
    bus.awaddr = a;
    bus.awvalid = aw_dly == 0;
    for (int t = 0; t < 200 && !(ad && wd); t++) begin
      if (bus.awvalid && bus.awready) begin ad = 1; last = cyc; end
      if (bus.wvalid && bus.wready) begin wd = 1; last = cyc; end
      @(negedge clk);
      if (ad) bus.awvalid = 1'b0;
      if (wd) bus.wvalid = 1'b0;
      if (!ad && t + 1 >= aw_dly) bus.awvalid = 1'b1;
`ifndef AXIL_MEM_STALL_EN
      if (wd && !ad && aw_dly > 0 && !seen) begin
        check("w_first_readies", {62'd0, bus.wready, bus.awready}, 64'b01);
        seen = 1;
      end
`endif
    end
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    if (ad && wd)
      for (int t = 0; t < 100 && !bus.bvalid; t++) @(negedge clk);
    e = bq.pop_front();
    if (!(ad && wd && bus.bvalid)) begin
      check("b_timeout", 0, 1);
    end else begin
      check("b_latency", 64'(cyc - last), 64'(1 + WR_LAT));
      check("bresp", bus.bresp, e);
      if (e == 2'b00) begin
        tmp = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) tmp[i*8 +: 8] = d[i*8 +: 8];
        mdl[widx(a)] = tmp;
      end
      @(negedge clk);
    end
    bus.bready = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, input int hold);
    bit ad = 0;
    int last = 0;
    rexp_t e;
    e.resp = exp_resp(a);
    e.data = e.resp == 2'b00 ? mdl[widx(a)] : 32'h0;
    rq.push_back(e);
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr = a;
    bus.rready = 1'b0;
    for (int t = 0; t < 200 && !ad; t++) begin
      if (bus.arready) begin ad = 1; last = cyc; end
      @(negedge clk);
    end
    bus.arvalid = 1'b0;
    if (ad)
      for (int t = 0; t < 100 && !bus.rvalid; t++) @(negedge clk);
    if (!(ad && bus.rvalid)) begin
      check("r_timeout", 0, 1);
      void'(rq.pop_front());
      return;
    end
    check("r_latency", 64'(cyc - last), 64'(1 + RD_LAT));
    for (int h = 0; h < hold; h++) begin
      check("r_hold_valid", bus.rvalid, 1);
      check("r_hold_data", bus.rdata, rq[0].data);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    e = rq.pop_front();
    check("rdata", bus.rdata, e.data);
    check("rresp", bus.rresp, e.resp);
    @(negedge clk);
    bus.rready = 1'b0;
    check("r_done_valid", bus.rvalid, 0);
  endtask
  initial begin
    logic [31:0] a;
    int seen_rv;
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                            bus.rresp, bus.bresp, bus.rdata}, 0);
    rst = 1'b0;
    #1;
`ifndef AXIL_MEM_STALL_EN
    check("post_reset_readies", {bus.arready, bus.awready, bus.wready}, 3'b111);
`endif
    do_write(BASE + 32'h10, 32'hDEEDBEEF, 4'hF, 0);
    do_read(BASE + 32'h10, 0);
    do_write(BASE + 32'h20, 32'h11223344, 4'hF, 0);
    do_write(BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    do_read(BASE + 32'h20, 0);
    do_write(BASE + 32'h30, 32'h12345678, 4'hF, 4);
    do_read(BASE + 32'h30, 0);
    do_read(32'h7FFF_FFFC, 0);
    do_read(BASE + 32'h2, 0);
    do_write(BASE, 32'hCAFEBABE, 4'hF, 0);
    do_write(BASE + 32'h4000, 32'hFFFFFFFF, 4'hF, 0);
    do_read(BASE, 0);
    do_write(BASE + 32'h50, 32'h5A5A1234, 4'hF, 0);
    do_read(BASE + 32'h50, 4);
`ifndef AXIL_MEM_STALL_EN
    do_write(BASE + 32'h40, 32'h0BADF00D, 4'hF, 0);
    fork
      do_read(BASE + 32'h40, 0);
      do_write(BASE + 32'h40, 32'h600DCAFE, 4'hF, 0);
    join
    do_read(BASE + 32'h40, 0);
`endif
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr = BASE + 32'h10;
    @(negedge clk);
    bus.arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {bus.arready, bus.rvalid, bus.rdata}, 0);
    rst = 1'b0;
    #1;
`ifndef AXIL_MEM_STALL_EN
    check("rst_arready", bus.arready, 1);
`endif
    seen_rv = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.rvalid) seen_rv++;
    end
    check("rst_no_rvalid", 64'(seen_rv), 0);
    for (int k = 0; k < 16; k++) do_write(BASE + 32'h100 + 32'(k * 4), $urandom, 4'hF, 0);
    for (int n = 0; n < NRAND; n++) begin
      a = BASE + 32'h100 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      else do_read(a, int'($urandom_range(0, 2)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
